// File: rtl/pipeline_stage_execution_pkg.sv
// Shared execution-stage types: ALU/mul-div opcodes, stage bundles,
// operand selection and the per-operand forwarding resolver.
package pipeline_stage_execution_pkg;

  localparam logic [4:0] ZERO = 5'd0;

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_AND, ALU_OR,
    ALU_XOR, ALU_NOR, ALU_SLT, ALU_SLTU,
    ALU_SLL, ALU_SRL, ALU_SRA, ALU_LUI
  } alu_op_t;

  typedef enum logic [3:0] {
    MD_NONE, MD_MULT, MD_MULTU, MD_DIV, MD_DIVU,
    MD_MFHI, MD_MFLO, MD_MTHI, MD_MTLO
  } muldiv_op_t;

  typedef enum logic [1:0] {
    MULDIV_IDLE, MULDIV_MUL, MULDIV_DIV
  } muldiv_state_t;

  typedef struct packed {
    alu_op_t    aluOp;
    muldiv_op_t mdOp;
    logic       useImm;
    logic       memRead;
    logic       memWrite;
    logic       regWrite;
  } signals_t;

  typedef struct packed {
    logic [4:0]  id;
    logic        dataReady;
    logic [31:0] data;
  } stage_register_data_t;

  typedef struct packed {
    logic        bubbled;
    logic [31:0] programCounter;
    logic [7:0]  programCounterChangedTimes;
    logic [31:0] instruction;
    signals_t    signals;
    logic [4:0]  regReadId1;
    logic [4:0]  regReadId2;
    logic [31:0] regReadData1;
    logic [31:0] regReadData2;
    logic [4:0]  regWriteId;
  } pipeline_result_decode_t;

  typedef struct packed {
    logic        bubbled;
    logic [31:0] programCounter;
    logic [7:0]  programCounterChangedTimes;
    logic [31:0] instruction;
    signals_t    signals;
    logic [4:0]  regReadId1;
    logic [4:0]  regReadId2;
    logic [4:0]  regWriteId;
    logic        regDataWriteReady;
    logic [31:0] regDataWrite;
    logic [31:0] dmAddress;
    logic [31:0] dmWriteData;
  } pipeline_result_execution_t;

  typedef struct packed {
    logic        stall;
    logic [31:0] data;
  } fwd_t;

  function automatic logic [31:0] selectAluOperand2(
    signals_t s, logic [31:0] regData, logic [15:0] imm);
    return s.useImm ? {{16{imm[15]}}, imm} : regData;
  endfunction

  // Memory stage wins over writeback; $0 is never forwarded.
  function automatic fwd_t forwardOperand(
    logic [4:0] id, logic [31:0] regData,
    stage_register_data_t mem, stage_register_data_t wb);
    fwd_t f;
    f.stall = 1'b0;
    f.data  = regData;
    if (id != ZERO && mem.id == id) begin
      f.data  = mem.data;
      f.stall = !mem.dataReady;
    end else if (id != ZERO && wb.id == id) begin
      f.data  = wb.data;
      f.stall = !wb.dataReady;
    end
    return f;
  endfunction

endpackage

// File: rtl/pipeline_stage_execution_mult_div_unit.sv
// Iterative shift-add multiplier / restoring divider owning HI and LO.
// Results land one cycle after the last step; hi/lo bypass that write.
module mult_div_unit
  import pipeline_stage_execution_pkg::*;
#(
  parameter int MUL_CYCLES = 32,
  parameter int DIV_CYCLES = 32
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic        mtWrite,
  input  muldiv_op_t  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int MUL_BITS = (32 + MUL_CYCLES - 1) / MUL_CYCLES;
  localparam logic [5:0] MUL_CNT = 6'(MUL_CYCLES);
  localparam logic [5:0] DIV_CNT = 6'(DIV_CYCLES);

  muldiv_state_t r_state;
  logic [5:0]  r_cnt;
  logic [63:0] r_acc;
  logic [63:0] r_mcand;
  logic [31:0] r_mplier;
  logic [31:0] r_divisor;
  logic [31:0] r_dividend;
  logic        r_negLo;
  logic        r_negHi;
  logic        r_divZero;
  logic [31:0] r_hi;
  logic [31:0] r_lo;

  logic        w_signed;
  logic        w_isMul;
  logic [31:0] w_aMag;
  logic [31:0] w_bMag;
  logic [63:0] w_mulAcc;
  logic [32:0] w_divShift;
  logic        w_divFits;
  logic [31:0] w_divRem;
  logic [63:0] w_divAcc;
  logic [63:0] w_prod;
  logic        w_done;
  logic [31:0] w_resHi;
  logic [31:0] w_resLo;

  assign w_signed = (op == MD_MULT) || (op == MD_DIV);
  assign w_isMul  = (op == MD_MULT) || (op == MD_MULTU);
  assign w_aMag   = (w_signed && a[31]) ? -a : a;
  assign w_bMag   = (w_signed && b[31]) ? -b : b;

  always_comb begin
    w_mulAcc = r_acc;
    for (int k = 0; k < MUL_BITS; k++) begin
      if (r_mplier[k]) w_mulAcc = w_mulAcc + (r_mcand << k);
    end
  end

  assign w_divShift = {r_acc[63:32], r_acc[31]};
  assign w_divFits  = w_divShift >= {1'b0, r_divisor};
  assign w_divRem   = w_divShift[31:0] - r_divisor;
  assign w_divAcc   = w_divFits ?
    {w_divRem, r_acc[30:0], 1'b1} :
    {w_divShift[31:0], r_acc[30:0], 1'b0};

  assign w_prod = r_negLo ? -r_acc : r_acc;
  assign w_done = (r_state != MULDIV_IDLE) && (r_cnt == 6'd0);

  always_comb begin
    w_resHi = r_hi;
    w_resLo = r_lo;
    if (r_state == MULDIV_MUL) begin
      w_resHi = w_prod[63:32];
      w_resLo = w_prod[31:0];
    end else if (r_state == MULDIV_DIV) begin
      if (r_divZero) begin
        w_resHi = r_dividend;
        w_resLo = 32'hFFFF_FFFF;
      end else begin
        w_resHi = r_negHi ? -r_acc[63:32] : r_acc[63:32];
        w_resLo = r_negLo ? -r_acc[31:0] : r_acc[31:0];
      end
    end
  end

  assign busy = r_state != MULDIV_IDLE;
  assign hi   = w_done ? w_resHi : r_hi;
  assign lo   = w_done ? w_resLo : r_lo;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state    <= MULDIV_IDLE;
      r_cnt      <= '0;
      r_acc      <= '0;
      r_mcand    <= '0;
      r_mplier   <= '0;
      r_divisor  <= '0;
      r_dividend <= '0;
      r_negLo    <= 1'b0;
      r_negHi    <= 1'b0;
      r_divZero  <= 1'b0;
      r_hi       <= '0;
      r_lo       <= '0;
    end else begin
      unique case (r_state)
        MULDIV_IDLE: begin
          if (start && w_isMul) begin
            r_state  <= MULDIV_MUL;
            r_cnt    <= MUL_CNT;
            r_acc    <= '0;
            r_mcand  <= {32'b0, w_aMag};
            r_mplier <= w_bMag;
            r_negLo  <= w_signed & (a[31] ^ b[31]);
          end else if (start) begin
            r_state    <= MULDIV_DIV;
            r_cnt      <= DIV_CNT;
            r_acc      <= {32'b0, w_aMag};
            r_divisor  <= w_bMag;
            r_dividend <= a;
            r_divZero  <= b == 32'd0;
            r_negLo    <= w_signed & (a[31] ^ b[31]);
            r_negHi    <= w_signed & a[31];
          end else if (mtWrite && op == MD_MTHI) begin
            r_hi <= a;
          end else if (mtWrite && op == MD_MTLO) begin
            r_lo <= a;
          end
        end
        MULDIV_MUL: begin
          if (r_cnt == 6'd0) begin
            r_hi    <= w_resHi;
            r_lo    <= w_resLo;
            r_state <= MULDIV_IDLE;
          end else begin
            r_acc    <= w_mulAcc;
            r_mcand  <= r_mcand << MUL_BITS;
            r_mplier <= r_mplier >> MUL_BITS;
            r_cnt    <= r_cnt - 6'd1;
          end
        end
        MULDIV_DIV: begin
          if (r_cnt == 6'd0) begin
            r_hi    <= w_resHi;
            r_lo    <= w_resLo;
            r_state <= MULDIV_IDLE;
          end else begin
            r_acc <= w_divAcc;
            r_cnt <= r_cnt - 6'd1;
          end
        end
        default: r_state <= MULDIV_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/pipeline_stage_execution.sv
// Execute stage: operand forwarding, ALU, DM address, HI/LO access
// and hazard stall generation toward decode.
module pipeline_stage_execution
  import pipeline_stage_execution_pkg::*;
#(
  parameter int MUL_CYCLES = 32,
  parameter int DIV_CYCLES = 32
) (
  input  logic                       clock,
  input  logic                       reset,
  input  pipeline_result_decode_t    pipelineResultDecode,
  input  stage_register_data_t       resultAfterMemory,
  input  stage_register_data_t       resultAfterWriteback,
  output pipeline_result_execution_t pipelineResultExecution,
  output stage_register_data_t       resultOfInstructionAfterExecution,
  output logic                       stall
);

  pipeline_result_decode_t    w_dec;
  pipeline_result_execution_t w_next;
  pipeline_result_execution_t r_out;
  fwd_t        w_fwd1;
  fwd_t        w_fwd2;
  logic [31:0] w_op2;
  logic [31:0] w_alu;
  logic        w_isMd;
  logic        w_isMulDiv;
  logic        w_isMt;
  logic        w_busy;
  logic        w_issue;
  logic [31:0] w_hi;
  logic [31:0] w_lo;

  assign w_dec  = pipelineResultDecode;
  assign w_fwd1 = forwardOperand(w_dec.regReadId1, w_dec.regReadData1,
                                 resultAfterMemory, resultAfterWriteback);
  assign w_fwd2 = forwardOperand(w_dec.regReadId2, w_dec.regReadData2,
                                 resultAfterMemory, resultAfterWriteback);
  assign w_op2  = selectAluOperand2(w_dec.signals, w_fwd2.data,
                                    w_dec.instruction[15:0]);

  assign w_isMd     = w_dec.signals.mdOp != MD_NONE;
  assign w_isMulDiv = w_dec.signals.mdOp inside
    {MD_MULT, MD_MULTU, MD_DIV, MD_DIVU};
  assign w_isMt     = w_dec.signals.mdOp inside {MD_MTHI, MD_MTLO};

  assign stall   = !reset && !w_dec.bubbled &&
                   (w_fwd1.stall || w_fwd2.stall || (w_busy && w_isMd));
  assign w_issue = !reset && !w_dec.bubbled && !stall;

  mult_div_unit #(
    .MUL_CYCLES(MUL_CYCLES),
    .DIV_CYCLES(DIV_CYCLES)
  ) u_mdu (
    .clock  (clock),
    .reset  (reset),
    .start  (w_issue && w_isMulDiv),
    .mtWrite(w_issue && w_isMt),
    .op     (w_dec.signals.mdOp),
    .a      (w_fwd1.data),
    .b      (w_fwd2.data),
    .busy   (w_busy),
    .hi     (w_hi),
    .lo     (w_lo)
  );

  always_comb begin
    w_alu = '0;
    unique case (w_dec.signals.aluOp)
      ALU_ADD:  w_alu = w_fwd1.data + w_op2;
      ALU_SUB:  w_alu = w_fwd1.data - w_op2;
      ALU_AND:  w_alu = w_fwd1.data & w_op2;
      ALU_OR:   w_alu = w_fwd1.data | w_op2;
      ALU_XOR:  w_alu = w_fwd1.data ^ w_op2;
      ALU_NOR:  w_alu = ~(w_fwd1.data | w_op2);
      ALU_SLT:  w_alu = {31'b0, $signed(w_fwd1.data) < $signed(w_op2)};
      ALU_SLTU: w_alu = {31'b0, w_fwd1.data < w_op2};
      ALU_SLL:  w_alu = w_fwd1.data << w_op2[4:0];
      ALU_SRL:  w_alu = w_fwd1.data >> w_op2[4:0];
      ALU_SRA:  w_alu = $unsigned($signed(w_fwd1.data) >>> w_op2[4:0]);
      ALU_LUI:  w_alu = {w_op2[15:0], 16'h0};
      default:  w_alu = '0;
    endcase
  end

  always_comb begin
    w_next.bubbled                    = w_dec.bubbled;
    w_next.programCounter             = w_dec.programCounter;
    w_next.programCounterChangedTimes = w_dec.programCounterChangedTimes;
    w_next.instruction                = w_dec.instruction;
    w_next.signals                    = w_dec.signals;
    w_next.regReadId1                 = w_dec.regReadId1;
    w_next.regReadId2                 = w_dec.regReadId2;
    w_next.regWriteId  = w_dec.signals.regWrite ? w_dec.regWriteId : ZERO;
    w_next.regDataWriteReady = !w_dec.signals.memRead;
    w_next.dmAddress   = w_fwd1.data +
                         {{16{w_dec.instruction[15]}}, w_dec.instruction[15:0]};
    w_next.dmWriteData = w_fwd2.data;
    unique case (1'b1)
      w_dec.signals.mdOp == MD_MFHI: w_next.regDataWrite = w_hi;
      w_dec.signals.mdOp == MD_MFLO: w_next.regDataWrite = w_lo;
      default:                       w_next.regDataWrite = w_alu;
    endcase
  end

  // A stalled cycle injects a bubble but keeps the payload fields.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_out         <= '0;
      r_out.bubbled <= 1'b1;
    end else if (stall) begin
      r_out.bubbled <= 1'b1;
    end else begin
      r_out <= w_next;
    end
  end

  assign pipelineResultExecution = r_out;

  always_comb begin
    if (r_out.bubbled) begin
      resultOfInstructionAfterExecution = {ZERO, 1'b1, 32'h0};
    end else begin
      resultOfInstructionAfterExecution =
        {r_out.regWriteId, r_out.regDataWriteReady, r_out.regDataWrite};
    end
  end

endmodule

// File: tb/tb_pipeline_stage_execution.sv
// Self-checking bench: ALU vector table, forwarding/stall sequences,
// mul/div against an arithmetic model, and randomized ALU traffic.
module tb_pipeline_stage_execution;
  import pipeline_stage_execution_pkg::*;

  localparam int MC = 32;

  logic clock = 1'b0;
  logic reset;
  pipeline_result_decode_t    dec;
  stage_register_data_t       memF;
  stage_register_data_t       wbF;
  stage_register_data_t       fwdOut;
  pipeline_result_execution_t exOut;
  logic stall;
  int total = 0;
  int bad = 0;

  always #5 clock = ~clock;

  pipeline_stage_execution #(.MUL_CYCLES(MC), .DIV_CYCLES(32)) dut (
    .clock                            (clock),
    .reset                            (reset),
    .pipelineResultDecode             (dec),
    .resultAfterMemory                (memF),
    .resultAfterWriteback             (wbF),
    .pipelineResultExecution          (exOut),
    .resultOfInstructionAfterExecution(fwdOut),
    .stall                            (stall)
  );

  typedef struct {
    alu_op_t     op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    string       nm;
  } vec_t;

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  function automatic pipeline_result_decode_t mk(
    alu_op_t aop, muldiv_op_t mop, logic [4:0] r1, logic [31:0] d1,
    logic [4:0] r2, logic [31:0] d2, logic [4:0] wid);
    pipeline_result_decode_t d;
    d = '0;
    d.programCounter   = 32'h400;
    d.signals.aluOp    = aop;
    d.signals.mdOp     = mop;
    d.signals.regWrite = wid != 5'd0;
    d.regReadId1       = r1;
    d.regReadData1     = d1;
    d.regReadId2       = r2;
    d.regReadData2     = d2;
    d.regWriteId       = wid;
    return d;
  endfunction

  function automatic pipeline_result_decode_t bub();
    pipeline_result_decode_t d;
    d = '0;
    d.bubbled = 1'b1;
    return d;
  endfunction

  function automatic logic [31:0] aluRef(alu_op_t op, logic [31:0] a,
                                         logic [31:0] b);
    logic [4:0] n;
    logic [31:0] r;
    n = b[4:0];
    case (op)
      ALU_ADD:  return a + b;
      ALU_SUB:  return a + ~b + 32'd1;
      ALU_AND:  return a & b;
      ALU_OR:   return a | b;
      ALU_XOR:  return a ^ b;
      ALU_NOR:  return ~(a | b);
      ALU_SLT:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      ALU_SLTU: return (a < b) ? 32'd1 : 32'd0;
      ALU_SLL:  return a << n;
      ALU_SRL:  return a >> n;
      ALU_SRA: begin
        r = a >> n;
        if (a[31]) r = r | ~(32'hFFFF_FFFF >> n);
        return r;
      end
      ALU_LUI:  return b * 32'h10000;
      default:  return 32'h0;
    endcase
  endfunction

  task automatic mdRef(muldiv_op_t op, logic [31:0] a, logic [31:0] b,
                       output logic [31:0] eh, output logic [31:0] el);
    longint sa, sb, q, r;
    logic [63:0] p;
    eh = 0;
    el = 0;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    if (op == MD_MULT || op == MD_MULTU) begin
      if (op == MD_MULT) p = 64'(sa * sb);
      else p = {32'b0, a} * {32'b0, b};
      eh = p[63:32];
      el = p[31:0];
    end else if (b == 32'd0) begin
      eh = a;
      el = 32'hFFFF_FFFF;
    end else if (op == MD_DIV) begin
      q = sa / sb;
      r = sa % sb;
      eh = r[31:0];
      el = q[31:0];
    end else begin
      el = a / b;
      eh = a % b;
    end
  endtask

  task automatic runMd(string nm, muldiv_op_t op, logic [31:0] a,
                       logic [31:0] b);
    logic [31:0] eh, el;
    int n;
    int want;
    mdRef(op, a, b, eh, el);
    want = (op == MD_MULT || op == MD_MULTU) ? MC + 1 : 33;
    dec = mk(ALU_ADD, op, 5'd1, a, 5'd2, b, 5'd0);
    #1;
    chk({nm, "_issue_stall"}, 64'(stall), 64'd0);
    tick();
    chk({nm, "_retire_fwd"}, 64'(fwdOut), 64'({ZERO, 1'b1, exOut.regDataWrite}));
    dec = mk(ALU_ADD, MD_MFLO, 5'd0, 0, 5'd0, 0, 5'd8);
    #1;
    n = 0;
    while (stall && n < 200) begin
      n++;
      tick();
    end
    chk({nm, "_stall_cycles"}, 64'(n), 64'(want));
    tick();
    chk({nm, "_lo"}, 64'(exOut.regDataWrite), 64'(el));
    dec = mk(ALU_ADD, MD_MFHI, 5'd0, 0, 5'd0, 0, 5'd9);
    #1;
    tick();
    chk({nm, "_hi"}, 64'(exOut.regDataWrite), 64'(eh));
    dec = bub();
  endtask

  task automatic readHiLo(string nm, logic [31:0] eh, logic [31:0] el);
    dec = mk(ALU_ADD, MD_MFHI, 5'd0, 0, 5'd0, 0, 5'd8);
    #1;
    chk({nm, "_mfhi_stall"}, 64'(stall), 64'd0);
    tick();
    chk({nm, "_hi"}, 64'(exOut.regDataWrite), 64'(eh));
    dec = mk(ALU_ADD, MD_MFLO, 5'd0, 0, 5'd0, 0, 5'd8);
    #1;
    tick();
    chk({nm, "_lo"}, 64'(exOut.regDataWrite), 64'(el));
    dec = bub();
  endtask

  vec_t vt[12];

  initial begin
    vt[0]  = '{ALU_ADD,  32'd7,         32'hFFFF_FFFF, 32'd6,         "add"};
    vt[1]  = '{ALU_SUB,  32'd5,         32'd7,         32'hFFFF_FFFE, "sub"};
    vt[2]  = '{ALU_AND,  32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000, "and"};
    vt[3]  = '{ALU_OR,   32'hF0F0_F0F0, 32'h0F0F_0000, 32'hFFFF_F0F0, "or"};
    vt[4]  = '{ALU_XOR,  32'hFFFF_0000, 32'hF0F0_F0F0, 32'h0F0F_F0F0, "xor"};
    vt[5]  = '{ALU_NOR,  32'h0,         32'h0,         32'hFFFF_FFFF, "nor"};
    vt[6]  = '{ALU_SLT,  32'hFFFF_FFFF, 32'd1,         32'd1,         "slt"};
    vt[7]  = '{ALU_SLTU, 32'hFFFF_FFFF, 32'd1,         32'd0,         "sltu"};
    vt[8]  = '{ALU_SLL,  32'd1,         32'd31,        32'h8000_0000, "sll31"};
    vt[9]  = '{ALU_SLL,  32'd1,         32'd32,        32'd1,         "sll32"};
    vt[10] = '{ALU_SRA,  32'h8000_0000, 32'd4,         32'hF800_0000, "sra"};
    vt[11] = '{ALU_LUI,  32'h0,         32'h0000_1234, 32'h1234_0000, "lui"};

    reset = 1'b1;
    dec   = bub();
    memF  = {ZERO, 1'b1, 32'h0};
    wbF   = {ZERO, 1'b1, 32'h0};
    tick();
    tick();
    chk("rst_bubbled", 64'(exOut.bubbled), 64'd1);
    chk("rst_fwd", 64'(fwdOut), 64'({ZERO, 1'b1, 32'h0}));
    chk("rst_stall", 64'(stall), 64'd0);
    reset = 1'b0;
    readHiLo("rst", 32'h0, 32'h0);

    for (int i = 0; i < 12; i++) begin
      dec = mk(vt[i].op, MD_NONE, 5'd1, vt[i].a, 5'd2, vt[i].b, 5'd3);
      dec.programCounter = 32'h400 + 32'(i * 4);
      #1;
      chk({vt[i].nm, "_stall"}, 64'(stall), 64'd0);
      tick();
      chk({vt[i].nm, "_data"}, 64'(exOut.regDataWrite), 64'(vt[i].exp));
      chk({vt[i].nm, "_fwd"}, 64'(fwdOut), 64'({5'd3, 1'b1, vt[i].exp}));
      chk({vt[i].nm, "_pc"}, 64'(exOut.programCounter), 64'(32'h400 + 32'(i * 4)));
    end

    memF = {5'd4, 1'b0, 32'h55};
    wbF  = {5'd4, 1'b1, 32'h99};
    dec  = mk(ALU_ADD, MD_NONE, 5'd4, 32'h0, 5'd2, 32'h10, 5'd5);
    #1;
    chk("lu_stall", 64'(stall), 64'd1);
    tick();
    chk("lu_bubble", 64'(exOut.bubbled), 64'd1);
    chk("lu_bubble_fwd", 64'(fwdOut), 64'({ZERO, 1'b1, 32'h0}));
    memF = {5'd4, 1'b1, 32'h55};
    #1;
    chk("lu_release", 64'(stall), 64'd0);
    tick();
    chk("lu_mem_data", 64'(exOut.regDataWrite), 64'h65);
    memF = {5'd6, 1'b1, 32'h1};
    #1;
    tick();
    chk("lu_wb_data", 64'(exOut.regDataWrite), 64'hA9);
    memF = {ZERO, 1'b0, 32'h1};
    wbF  = {ZERO, 1'b1, 32'h2};
    dec  = mk(ALU_ADD, MD_NONE, 5'd0, 32'h7, 5'd2, 32'h10, 5'd5);
    #1;
    chk("zero_nostall", 64'(stall), 64'd0);
    tick();
    chk("zero_data", 64'(exOut.regDataWrite), 64'h17);

    dec = mk(ALU_ADD, MD_NONE, 5'd1, 32'h1000, 5'd0, 32'h0, 5'd7);
    dec.signals.memRead = 1'b1;
    dec.signals.useImm  = 1'b1;
    dec.instruction[15:0] = 16'hFFF0;
    #1;
    tick();
    chk("lw_addr", 64'(exOut.dmAddress), 64'h0FF0);
    chk("lw_fwd", 64'(fwdOut), 64'({5'd7, 1'b0, exOut.regDataWrite}));

    runMd("mult_m3x5", MD_MULT, 32'hFFFF_FFFD, 32'd5);
    readHiLo("mult_const", 32'hFFFF_FFFF, 32'hFFFF_FFF1);
    runMd("div_by0", MD_DIV, 32'd7, 32'd0);
    readHiLo("div_by0_const", 32'd7, 32'hFFFF_FFFF);
    runMd("div_ovf", MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    readHiLo("div_ovf_const", 32'h0, 32'h8000_0000);
    runMd("divu_100_7", MD_DIVU, 32'd100, 32'd7);
    readHiLo("divu_const", 32'd2, 32'd14);
    runMd("multu_max", MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    runMd("div_negrem", MD_DIV, 32'hFFFF_FFF9, 32'd2);
    for (int i = 0; i < 4; i++) begin
      runMd("md_rand", muldiv_op_t'($urandom_range(1, 4)), $urandom, $urandom);
    end

    dec = mk(ALU_ADD, MD_MTHI, 5'd1, 32'hCAFE, 5'd0, 32'h0, 5'd0);
    #1;
    tick();
    dec = mk(ALU_ADD, MD_MTLO, 5'd1, 32'hBEEF, 5'd0, 32'h0, 5'd0);
    #1;
    tick();
    readHiLo("mt", 32'hCAFE, 32'hBEEF);

    dec = mk(ALU_ADD, MD_DIV, 5'd1, 32'd1000, 5'd2, 32'd3, 5'd0);
    #1;
    tick();
    dec = bub();
    repeat (9) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    dec = mk(ALU_ADD, MD_MFHI, 5'd0, 0, 5'd0, 0, 5'd8);
    #1;
    chk("rstdiv_bubbled", 64'(exOut.bubbled), 64'd1);
    chk("rstdiv_fwd", 64'(fwdOut), 64'({ZERO, 1'b1, 32'h0}));
    chk("rstdiv_stall", 64'(stall), 64'd0);
    dec = bub();
    repeat (40) tick();
    readHiLo("rstdiv", 32'h0, 32'h0);

    dec = mk(ALU_ADD, MD_MULTU, 5'd1, 32'd6, 5'd2, 32'd7, 5'd0);
    #1;
    tick();
    dec = bub();
    dec.signals.mdOp = MD_MTLO;
    dec.regReadId1   = 5'd1;
    dec.regReadData1 = 32'hDEAD;
    #1;
    chk("bub_busy_stall", 64'(stall), 64'd0);
    tick();
    chk("bub_busy_out", 64'(exOut.bubbled), 64'd1);
    dec = bub();
    repeat (40) tick();
    readHiLo("bub_busy", 32'h0, 32'd42);

    for (int i = 0; i < 120; i++) begin
      alu_op_t op;
      logic [4:0] id1, id2;
      logic [31:0] d1, d2, v1, v2, b, ea;
      logic s1, s2, useImm;
      logic [15:0] imm;
      op = alu_op_t'($urandom_range(0, 11));
      id1 = 5'($urandom_range(0, 3));
      id2 = 5'($urandom_range(0, 3));
      d1 = $urandom;
      d2 = $urandom;
      imm = 16'($urandom);
      useImm = 1'($urandom_range(0, 1));
      memF = {5'($urandom_range(0, 3)), ($urandom_range(0, 3) != 0), 32'($urandom)};
      wbF  = {5'($urandom_range(0, 3)), ($urandom_range(0, 3) != 0), 32'($urandom)};
      v1 = d1; s1 = 1'b0;
      if (id1 != 0 && memF.id == id1) begin v1 = memF.data; s1 = !memF.dataReady; end
      else if (id1 != 0 && wbF.id == id1) begin v1 = wbF.data; s1 = !wbF.dataReady; end
      v2 = d2; s2 = 1'b0;
      if (id2 != 0 && memF.id == id2) begin v2 = memF.data; s2 = !memF.dataReady; end
      else if (id2 != 0 && wbF.id == id2) begin v2 = wbF.data; s2 = !wbF.dataReady; end
      b  = useImm ? {{16{imm[15]}}, imm} : v2;
      ea = v1 + {{16{imm[15]}}, imm};
      dec = mk(op, MD_NONE, id1, d1, id2, d2, 5'd9);
      dec.signals.useImm = useImm;
      dec.instruction[15:0] = imm;
      #1;
      chk("rnd_stall", 64'(stall), 64'(s1 | s2));
      tick();
      if (s1 | s2) begin
        chk("rnd_bubble", 64'(exOut.bubbled), 64'd1);
      end else begin
        chk("rnd_data", 64'(exOut.regDataWrite), 64'(aluRef(op, v1, b)));
        chk("rnd_addr", 64'(exOut.dmAddress), 64'(ea));
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
